// File: rtl/logic_rs.sv
// logic_rs: reservation station and oldest-first issue scheduler for the logic/shift FU.
// Optional macro LOGIC_RS_BYPASS_EN: ready dispatches skip the station when nothing is eligible.
module logic_rs #(
    parameter int unsigned RS_ENTRY     = 4,
    parameter int unsigned WORD_SIZE_P  = 16,
    parameter int unsigned WIDTH_OP     = 4,
    parameter int unsigned ROB_ENTRY    = 16,
    parameter int unsigned NUM_PHYS_REG = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            flush_i,
    input  logic                            disp_v_i,
    output logic                            disp_ready_o,
    input  logic [WIDTH_OP-1:0]             disp_opcode_i,
    input  logic                            disp_op1_rdy_i,
    input  logic [WORD_SIZE_P-1:0]          disp_op1_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] disp_op1_tag_i,
    input  logic                            disp_op2_rdy_i,
    input  logic [WORD_SIZE_P-1:0]          disp_op2_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] disp_op2_tag_i,
    input  logic [$clog2(ROB_ENTRY)-1:0]    disp_rob_dest_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] disp_reg_dest_i,
    input  logic                            cdb_v_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] cdb_dest_i,
    input  logic [WORD_SIZE_P-1:0]          cdb_result_i,
    output logic                            exe_v_o,
    output logic [WIDTH_OP-1:0]             opcode_o,
    output logic [WORD_SIZE_P-1:0]          operand1_o,
    output logic [WORD_SIZE_P-1:0]          operand2_o,
    output logic [$clog2(ROB_ENTRY)-1:0]    rob_dest_o,
    output logic [$clog2(NUM_PHYS_REG)-1:0] reg_dest_o,
    output logic [$clog2(RS_ENTRY):0]       count_o
);

    localparam int unsigned ROB_W = $clog2(ROB_ENTRY);
    localparam int unsigned PT_W  = $clog2(NUM_PHYS_REG);
    localparam int unsigned IDX_W = $clog2(RS_ENTRY);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef struct packed {
        logic                   vld;
        logic [WIDTH_OP-1:0]    opcode;
        logic                   rdy1;
        logic [WORD_SIZE_P-1:0] val1;
        logic [PT_W-1:0]        tag1;
        logic                   rdy2;
        logic [WORD_SIZE_P-1:0] val2;
        logic [PT_W-1:0]        tag2;
        logic [ROB_W-1:0]       rob;
        logic [PT_W-1:0]        rd;
    } entry_t;

    entry_t              ent_q [RS_ENTRY];
    entry_t              woke  [RS_ENTRY];
    entry_t              ent_d [RS_ENTRY];
    entry_t              disp_e;
    entry_t              issue_e;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [RS_ENTRY-1:0] elig;
    logic [IDX_W-1:0]    sel;
    logic [IDX_W-1:0]    wr_idx;
    logic                issue;
    logic                disp_fire;
    logic                bypass;
    logic                alloc;

    assign disp_ready_o = (cnt_q < CNT_W'(RS_ENTRY));
    assign disp_fire    = disp_v_i && disp_ready_o && !flush_i;
    assign count_o      = cnt_q;

    // CDB snoop on stored entries
    always_comb begin
        for (int i = 0; i < RS_ENTRY; i++) begin
            woke[i] = ent_q[i];
            if (cdb_v_i && ent_q[i].vld && !ent_q[i].rdy1 && ent_q[i].tag1 == cdb_dest_i) begin
                woke[i].rdy1 = 1'b1;
                woke[i].val1 = cdb_result_i;
            end
            if (cdb_v_i && ent_q[i].vld && !ent_q[i].rdy2 && ent_q[i].tag2 == cdb_dest_i) begin
                woke[i].rdy2 = 1'b1;
                woke[i].val2 = cdb_result_i;
            end
            elig[i] = ent_q[i].vld && ent_q[i].rdy1 && ent_q[i].rdy2;
        end
    end

    // Incoming op, with same-cycle CDB capture so a broadcast is never missed
    always_comb begin
        disp_e        = '0;
        disp_e.vld    = 1'b1;
        disp_e.opcode = disp_opcode_i;
        disp_e.rdy1   = disp_op1_rdy_i;
        disp_e.val1   = disp_op1_i;
        disp_e.tag1   = disp_op1_tag_i;
        disp_e.rdy2   = disp_op2_rdy_i;
        disp_e.val2   = disp_op2_i;
        disp_e.tag2   = disp_op2_tag_i;
        disp_e.rob    = disp_rob_dest_i;
        disp_e.rd     = disp_reg_dest_i;
        if (cdb_v_i && !disp_op1_rdy_i && disp_op1_tag_i == cdb_dest_i) begin
            disp_e.rdy1 = 1'b1;
            disp_e.val1 = cdb_result_i;
        end
        if (cdb_v_i && !disp_op2_rdy_i && disp_op2_tag_i == cdb_dest_i) begin
            disp_e.rdy2 = 1'b1;
            disp_e.val2 = cdb_result_i;
        end
    end

    // Oldest-first select: lowest eligible index wins
    always_comb begin
        sel   = '0;
        issue = 1'b0;
        for (int i = RS_ENTRY - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel   = IDX_W'(i);
                issue = 1'b1;
            end
        end
        issue_e = ent_q[sel];
    end

`ifdef LOGIC_RS_BYPASS_EN
    assign bypass = disp_fire && !issue && disp_e.rdy1 && disp_e.rdy2;
`else
    assign bypass = 1'b0;
`endif

    assign alloc  = disp_fire && !bypass;
    assign wr_idx = IDX_W'(cnt_q - CNT_W'(issue));
    assign cnt_d  = cnt_q + CNT_W'(alloc) - CNT_W'(issue);

    // Collapse above the issued slot, then append the dispatched op at the new tail
    always_comb begin
        for (int i = 0; i < RS_ENTRY - 1; i++) begin
            ent_d[i] = (issue && i >= int'(sel)) ? woke[i+1] : woke[i];
        end
        ent_d[RS_ENTRY-1] = issue ? '0 : woke[RS_ENTRY-1];
        for (int i = 0; i < RS_ENTRY; i++) begin
            if (alloc && IDX_W'(i) == wr_idx) begin
                ent_d[i] = disp_e;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < RS_ENTRY; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q      <= '0;
            exe_v_o    <= 1'b0;
            opcode_o   <= '0;
            operand1_o <= '0;
            operand2_o <= '0;
            rob_dest_o <= '0;
            reg_dest_o <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < RS_ENTRY; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q   <= '0;
            exe_v_o <= 1'b0;
        end else begin
            for (int i = 0; i < RS_ENTRY; i++) begin
                ent_q[i] <= ent_d[i];
            end
            cnt_q <= cnt_d;
            if (issue) begin
                exe_v_o    <= 1'b1;
                opcode_o   <= issue_e.opcode;
                operand1_o <= issue_e.val1;
                operand2_o <= issue_e.val2;
                rob_dest_o <= issue_e.rob;
                reg_dest_o <= issue_e.rd;
            end else if (bypass) begin
                exe_v_o    <= 1'b1;
                opcode_o   <= disp_e.opcode;
                operand1_o <= disp_e.val1;
                operand2_o <= disp_e.val2;
                rob_dest_o <= disp_e.rob;
                reg_dest_o <= disp_e.rd;
            end else begin
                exe_v_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_rs.sv
// Directed self-checking bench for logic_rs; expectations follow LOGIC_RS_BYPASS_EN when defined.
module tb_logic_rs;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_XOR  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_LSLS = 4'd4;
    localparam logic [3:0] OP_ASRS = 4'd6;
    localparam logic [3:0] OP_RORS = 4'd7;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        flush_i;
    logic        disp_v_i;
    logic        disp_ready_o;
    logic [3:0]  disp_opcode_i;
    logic        disp_op1_rdy_i;
    logic [15:0] disp_op1_i;
    logic [4:0]  disp_op1_tag_i;
    logic        disp_op2_rdy_i;
    logic [15:0] disp_op2_i;
    logic [4:0]  disp_op2_tag_i;
    logic [3:0]  disp_rob_dest_i;
    logic [4:0]  disp_reg_dest_i;
    logic        cdb_v_i;
    logic [4:0]  cdb_dest_i;
    logic [15:0] cdb_result_i;
    logic        exe_v_o;
    logic [3:0]  opcode_o;
    logic [15:0] operand1_o;
    logic [15:0] operand2_o;
    logic [3:0]  rob_dest_o;
    logic [4:0]  reg_dest_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    logic_rs dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .flush_i         (flush_i),
        .disp_v_i        (disp_v_i),
        .disp_ready_o    (disp_ready_o),
        .disp_opcode_i   (disp_opcode_i),
        .disp_op1_rdy_i  (disp_op1_rdy_i),
        .disp_op1_i      (disp_op1_i),
        .disp_op1_tag_i  (disp_op1_tag_i),
        .disp_op2_rdy_i  (disp_op2_rdy_i),
        .disp_op2_i      (disp_op2_i),
        .disp_op2_tag_i  (disp_op2_tag_i),
        .disp_rob_dest_i (disp_rob_dest_i),
        .disp_reg_dest_i (disp_reg_dest_i),
        .cdb_v_i         (cdb_v_i),
        .cdb_dest_i      (cdb_dest_i),
        .cdb_result_i    (cdb_result_i),
        .exe_v_o         (exe_v_o),
        .opcode_o        (opcode_o),
        .operand1_o      (operand1_o),
        .operand2_o      (operand2_o),
        .rob_dest_o      (rob_dest_o),
        .reg_dest_o      (reg_dest_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        disp_v_i = 1'b0;
        cdb_v_i  = 1'b0;
        flush_i  = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic r1, input logic [15:0] v1, input logic [4:0] t1,
                        input logic r2, input logic [15:0] v2, input logic [4:0] t2,
                        input logic [3:0] rob, input logic [4:0] rd);
        disp_v_i        = 1'b1;
        disp_opcode_i   = op;
        disp_op1_rdy_i  = r1;
        disp_op1_i      = v1;
        disp_op1_tag_i  = t1;
        disp_op2_rdy_i  = r2;
        disp_op2_i      = v2;
        disp_op2_tag_i  = t2;
        disp_rob_dest_i = rob;
        disp_reg_dest_i = rd;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [15:0] val);
        cdb_v_i      = 1'b1;
        cdb_dest_i   = tag;
        cdb_result_i = val;
    endtask

    initial begin
        reset_n_i = 1'b0;
        idle();
        disp(OP_AND, 1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 5'd0, 4'd0, 5'd0);
        disp_v_i = 1'b0;
        cdb_dest_i = 5'd0;
        cdb_result_i = 16'h0;
        tick();
        tick();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_exe_v", 32'(exe_v_o), 32'd0);
        chk("rst_ready", 32'(disp_ready_o), 32'd1);
        chk("rst_opcode", 32'(opcode_o), 32'd0);
        chk("rst_operand1", 32'(operand1_o), 32'd0);
        reset_n_i = 1'b1;
        tick();

        // Ready AND: t+2 issue (t+1 with bypass)
        disp(OP_AND, 1'b1, 16'h00F0, 5'd0, 1'b1, 16'h0FF0, 5'd0, 4'd3, 5'd7);
        tick();
        idle();
`ifndef LOGIC_RS_BYPASS_EN
        chk("and_t1_exe_v", 32'(exe_v_o), 32'd0);
        chk("and_t1_count", 32'(count_o), 32'd1);
        tick();
`endif
        chk("and_exe_v", 32'(exe_v_o), 32'd1);
        chk("and_opcode", 32'(opcode_o), 32'(OP_AND));
        chk("and_op1", 32'(operand1_o), 32'h00F0);
        chk("and_op2", 32'(operand2_o), 32'h0FF0);
        chk("and_rob", 32'(rob_dest_o), 32'd3);
        chk("and_reg", 32'(reg_dest_o), 32'd7);
        chk("and_count", 32'(count_o), 32'd0);
        tick();
        chk("and_done_exe_v", 32'(exe_v_o), 32'd0);
        chk("hold_opcode", 32'(opcode_o), 32'(OP_AND));

        // Older XOR waits on tag 5; younger OR issues first
        disp(OP_XOR, 1'b1, 16'h1111, 5'd0, 1'b0, 16'h0, 5'd5, 4'd4, 5'd10);
        tick();
        chk("xor_c1_count", 32'(count_o), 32'd1);
        chk("xor_c1_exe_v", 32'(exe_v_o), 32'd0);
        disp(OP_OR, 1'b1, 16'h000F, 5'd0, 1'b1, 16'h00F0, 5'd0, 4'd2, 5'd9);
        tick();
`ifdef LOGIC_RS_BYPASS_EN
        chk("or_byp_exe_v", 32'(exe_v_o), 32'd1);
        chk("or_byp_opcode", 32'(opcode_o), 32'(OP_OR));
        chk("or_byp_count", 32'(count_o), 32'd1);
`else
        chk("or_c2_exe_v", 32'(exe_v_o), 32'd0);
        chk("or_c2_count", 32'(count_o), 32'd2);
`endif
        // AND waiting on tag 6 dispatched while OR leaves the station
        disp(OP_AND, 1'b1, 16'h0101, 5'd0, 1'b0, 16'h0, 5'd6, 4'd5, 5'd11);
        tick();
`ifdef LOGIC_RS_BYPASS_EN
        chk("or_c3_exe_v", 32'(exe_v_o), 32'd0);
`else
        chk("or_exe_v", 32'(exe_v_o), 32'd1);
        chk("or_opcode", 32'(opcode_o), 32'(OP_OR));
        chk("or_op2", 32'(operand2_o), 32'h00F0);
        chk("or_rob", 32'(rob_dest_o), 32'd2);
`endif
        chk("c3_count", 32'(count_o), 32'd2);
        idle();
        cdb(5'd5, 16'h1234);
        tick();
        chk("xor_wake_exe_v", 32'(exe_v_o), 32'd0);
        chk("xor_wake_count", 32'(count_o), 32'd2);
        idle();
        tick();
        chk("xor_exe_v", 32'(exe_v_o), 32'd1);
        chk("xor_opcode", 32'(opcode_o), 32'(OP_XOR));
        chk("xor_op1", 32'(operand1_o), 32'h1111);
        chk("xor_op2", 32'(operand2_o), 32'h1234);
        chk("xor_rob", 32'(rob_dest_o), 32'd4);
        chk("xor_count", 32'(count_o), 32'd1);
        cdb(5'd6, 16'h00AA);
        tick();
        chk("and2_wake_exe_v", 32'(exe_v_o), 32'd0);
        idle();
        tick();
        chk("and2_exe_v", 32'(exe_v_o), 32'd1);
        chk("and2_opcode", 32'(opcode_o), 32'(OP_AND));
        chk("and2_op2", 32'(operand2_o), 32'h00AA);
        chk("and2_rob", 32'(rob_dest_o), 32'd5);
        chk("and2_reg", 32'(reg_dest_o), 32'd11);
        chk("and2_count", 32'(count_o), 32'd0);
        tick();

        // Same-cycle CDB capture at dispatch
        disp(OP_LSLS, 1'b1, 16'h0003, 5'd0, 1'b0, 16'h0, 5'd9, 4'd6, 5'd12);
        cdb(5'd9, 16'hBEEF);
        tick();
        idle();
`ifndef LOGIC_RS_BYPASS_EN
        chk("cap_t1_exe_v", 32'(exe_v_o), 32'd0);
        chk("cap_t1_count", 32'(count_o), 32'd1);
        tick();
`endif
        chk("cap_exe_v", 32'(exe_v_o), 32'd1);
        chk("cap_opcode", 32'(opcode_o), 32'(OP_LSLS));
        chk("cap_op1", 32'(operand1_o), 32'h0003);
        chk("cap_op2", 32'(operand2_o), 32'hBEEF);
        chk("cap_count", 32'(count_o), 32'd0);
        tick();

        // Fill, drop a 5th dispatch, wake out of order and watch the collapse
        for (int k = 0; k < 4; k++) begin
            disp(OP_RORS, 1'b1, 16'(k), 5'd0, 1'b0, 16'h0, 5'(10 + k), 4'(k), 5'(k));
            tick();
        end
        idle();
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_ready", 32'(disp_ready_o), 32'd0);
        disp(OP_ASRS, 1'b1, 16'h0, 5'd0, 1'b0, 16'h0, 5'd14, 4'd8, 5'd0);
        tick();
        idle();
        chk("drop_count", 32'(count_o), 32'd4);
        chk("drop_exe_v", 32'(exe_v_o), 32'd0);
        cdb(5'd11, 16'h5555);
        tick();
        idle();
        chk("w1_pre_exe_v", 32'(exe_v_o), 32'd0);
        tick();
        chk("w1_exe_v", 32'(exe_v_o), 32'd1);
        chk("w1_rob", 32'(rob_dest_o), 32'd1);
        chk("w1_op1", 32'(operand1_o), 32'd1);
        chk("w1_op2", 32'(operand2_o), 32'h5555);
        chk("w1_count", 32'(count_o), 32'd3);
        chk("w1_ready", 32'(disp_ready_o), 32'd1);
        cdb(5'd12, 16'h6666);
        tick();
        idle();
        tick();
        chk("w2_rob", 32'(rob_dest_o), 32'd2);
        chk("w2_op2", 32'(operand2_o), 32'h6666);
        chk("w2_count", 32'(count_o), 32'd2);
        cdb(5'd13, 16'h7777);
        tick();
        idle();
        tick();
        chk("w3_rob", 32'(rob_dest_o), 32'd3);
        chk("w3_op1", 32'(operand1_o), 32'd3);
        cdb(5'd10, 16'h8888);
        tick();
        idle();
        tick();
        chk("w0_exe_v", 32'(exe_v_o), 32'd1);
        chk("w0_rob", 32'(rob_dest_o), 32'd0);
        chk("w0_count", 32'(count_o), 32'd0);
        cdb(5'd14, 16'h9999);
        tick();
        idle();
        tick();
        chk("dropped_exe_v", 32'(exe_v_o), 32'd0);
        chk("dropped_count", 32'(count_o), 32'd0);

        // Flush beats dispatch, issue and wakeup in the same cycle
        for (int k = 0; k < 4; k++) begin
            disp(OP_XOR, 1'b1, 16'h0, 5'd0, 1'b0, 16'h0, 5'(20 + k), 4'(k), 5'(k));
            tick();
        end
        idle();
        cdb(5'd20, 16'h0001);
        tick();
        flush_i = 1'b1;
        disp(OP_AND, 1'b1, 16'h1, 5'd0, 1'b1, 16'h2, 5'd0, 4'd9, 5'd9);
        cdb(5'd21, 16'h0002);
        tick();
        idle();
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_exe_v", 32'(exe_v_o), 32'd0);
        chk("flush_ready", 32'(disp_ready_o), 32'd1);
        tick();
        chk("flush_post_exe_v", 32'(exe_v_o), 32'd0);
        tick();
        chk("flush_post2_exe_v", 32'(exe_v_o), 32'd0);
        chk("flush_post_count", 32'(count_o), 32'd0);

        // Asynchronous reset while entries are held
        for (int k = 0; k < 3; k++) begin
            disp(OP_OR, 1'b1, 16'h0, 5'd0, 1'b0, 16'h0, 5'(24 + k), 4'(k), 5'(k));
            tick();
        end
        idle();
        chk("pre_rst_count", 32'(count_o), 32'd3);
        #2;
        reset_n_i = 1'b0;
        tick();
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_exe_v", 32'(exe_v_o), 32'd0);
        chk("mid_rst_ready", 32'(disp_ready_o), 32'd1);
        reset_n_i = 1'b1;
        tick();
        cdb(5'd24, 16'hAAAA);
        tick();
        idle();
        tick();
        chk("post_rst_exe_v", 32'(exe_v_o), 32'd0);
        chk("post_rst_count", 32'(count_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_rs.md
Name: logic_rs

Overview:
- Reservation station and issue scheduler for the logic/shift functional unit.
- Buffers dispatched logic ops (AND/XOR/OR/NEG/LSLS/LSRS/ASRS/RORS) until both source operands are available, snooping the CDB to wake them.
- Issues at most one ready op per cycle, oldest first, through a registered interface that drives the FU's exe_v_i/opcode_i/operand*_i/rob_dest_i/reg_dest_i inputs.
- Sits between rename/dispatch and the logic FU.

Parameters:
- RS_ENTRY, 4, number of station entries (>=2).
- WORD_SIZE_P, 16, operand/result width.
- WIDTH_OP, 4, opcode width.
- ROB_ENTRY, 16, ROB depth; the ROB tag is $clog2(ROB_ENTRY) bits.
- NUM_PHYS_REG, 32, physical registers; a physical tag (PT) is $clog2(NUM_PHYS_REG) bits.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous assert, active-low.
- flush_i  in  1  squash all entries (mispredict/exception).
- disp_v_i  in  1  dispatch request.
- disp_ready_o  out  1  station can accept a dispatch this cycle.
- disp_opcode_i  in  WIDTH_OP  op.
- disp_op1_rdy_i  in  1  op1 value already valid.
- disp_op1_i  in  WORD_SIZE_P  op1 value when ready.
- disp_op1_tag_i  in  PT  op1 producer tag when not ready.
- disp_op2_rdy_i, disp_op2_i, disp_op2_tag_i  in  1/WORD_SIZE_P/PT  same for op2.
- disp_rob_dest_i  in  $clog2(ROB_ENTRY)  ROB slot.
- disp_reg_dest_i  in  PT  destination physical register.
- cdb_v_i  in  1  CDB broadcast valid.
- cdb_dest_i  in  PT  CDB destination tag.
- cdb_result_i  in  WORD_SIZE_P  CDB value.
- exe_v_o  out  1  issue valid.
- opcode_o  out  WIDTH_OP  issued op.
- operand1_o, operand2_o  out  WORD_SIZE_P  issued operands.
- rob_dest_o  out  $clog2(ROB_ENTRY)  issued ROB slot.
- reg_dest_o  out  PT  issued destination register.
- count_o  out  $clog2(RS_ENTRY)+1  occupied entries.

Behaviour:

Reset and general
- reset_n_i low: all entries invalid, count_o=0, all issue outputs 0, disp_ready_o=1 (combinational from count). Reset applies mid-operation with no draining.

Entry storage and ordering
- Each entry holds: valid, opcode, per-operand {rdy, value, tag}, rob_dest, reg_dest.
- Collapsing queue: index 0 is oldest; valid entries are always contiguous from index 0.

Dispatch
- disp_ready_o = (count_o < RS_ENTRY). A same-cycle issue does not free a slot for dispatch.
- Dispatch fires when disp_v_i && disp_ready_o && !flush_i.
- The new entry is written at index count_o, or count_o-1 if an issue collapses the queue in the same cycle.
- disp_v_i while disp_ready_o=0 is dropped; dispatch must hold the op.

Wakeup
- Every cycle with cdb_v_i, each valid entry operand with rdy=0 and tag==cdb_dest_i sets rdy=1 and value=cdb_result_i.
- Wakeup also applies to the op being dispatched in the same cycle (tag match on the disp_*_tag_i with rdy=0), so a broadcast is never missed.
- Both operands of one entry may match the same broadcast.

Select and issue
- An entry is eligible when valid and both rdy bits are set, evaluated on registered state. An entry woken in cycle t is eligible in cycle t+1.
- The lowest-index eligible entry is selected.
- At the edge, the selected entry's fields load the output registers with exe_v_o=1. The entry is removed and entries above it shift down by one.
- No eligible entry: exe_v_o=0 next cycle; other output fields hold their previous values.

Latency
- Op dispatched ready in cycle t: exe_v_o=1 in cycle t+2 if no older eligible op.
- Throughput: 1 issue/cycle. The FU is always accepting, so there is no back-pressure.

count_o
- count_o(next) = count_o + dispatch - issue.

Flush
- flush_i: next edge, all entries invalid, count_o=0, exe_v_o=0.
- Flush has priority over same-cycle dispatch, issue and wakeup.

Optional Feature:
- Macro LOGIC_RS_BYPASS_EN.
- Defined: a dispatch with both operands ready (including same-cycle CDB capture) in a cycle with no eligible entry loads the output registers directly at that edge. exe_v_o=1 in cycle t+1, no entry is allocated, and count_o is unchanged. Requires disp_ready_o=1.
- Undefined: every dispatch is allocated, minimum latency 2 cycles.

Test Plan:
- Reset with reset_n_i low mid-traffic (3 entries held) -> next cycle count_o=0, exe_v_o=0, disp_ready_o=1.
- Dispatch AND op1=0x00F0 op2=0x0FF0 both ready, rob 3, reg 7 at t -> t+2 exe_v_o=1, opcode AND, operands 0x00F0/0x0FF0, rob_dest_o=3, reg_dest_o=7 (t+1 with LOGIC_RS_BYPASS_EN).
- Dispatch XOR with op2 waiting on tag 5, then younger ready OR -> OR issues first. cdb_v_i dest=5 result=0x1234 -> XOR issues next cycle with operand2_o=0x1234.
- Dispatch an op waiting on tag 9 in the same cycle as cdb_v_i dest=9 result=0xBEEF -> entry captures 0xBEEF and issues; no hang.
- Fill RS_ENTRY=4 non-ready entries -> disp_ready_o=0, a 5th dispatch is dropped, count_o=4. Wake index 1 -> issues, entries 2,3 shift to 1,2, count_o=3, disp_ready_o=1.
- flush_i asserted together with dispatch, issue and wakeup while 4 entries are held -> count_o=0, exe_v_o=0 next cycle, and the dispatched op is not stored.
